icache_refill_arb: RTL

//  Shares one L1->L2 refill port (pri_cache_refill_*) among NUM_REQ icache refill controllers (one per core/cluster).

---
 rtl/icache_refill_pkg.sv | 14 +
 rtl/rr_arb_core.sv | 28 ++
 rtl/icache_refill_arb.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/icache_refill_pkg.sv
// Shared types and helpers for the icache refill arbiter.
package icache_refill_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_HOLD, ARB_XFER} refill_arb_state_e;

    localparam int unsigned REFILL_BEATS = 16;

    // True on the final beat of a burst; len=1 selects the double-line burst.
    function automatic logic last_beat(input int unsigned cnt, input logic len,
                                       input int unsigned beats = REFILL_BEATS);
        return cnt == (len ? 2 * beats - 1 : beats - 1);
    endfunction

endpackage

// File: rtl/rr_arb_core.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping.
module rr_arb_core #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     sel_oh_o,
    output logic [IDX_W-1:0] sel_idx_o,
    output logic             valid_o
);

    always_comb begin
        sel_oh_o  = '0;
        sel_idx_o = '0;
        valid_o   = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin : g_scan
            logic [IDX_W-1:0] j;
            j = IDX_W'((32'(ptr_i) + k) % N);
            if (!valid_o && req_i[j]) begin
                valid_o     = 1'b1;
                sel_oh_o[j] = 1'b1;
                sel_idx_o   = j;
            end
        end
    end

endmodule

// File: rtl/icache_refill_arb.sv
// Shares one L2 refill port among NUM_REQ icache refill controllers; the
// selected requester owns the port until its whole burst has returned.
module icache_refill_arb
    import icache_refill_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 19,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned BEATS   = REFILL_BEATS
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ-1:0]        up_req_i,
    input  logic [NUM_REQ*ADDR_W-1:0] up_addr_i,
    input  logic [NUM_REQ-1:0]        up_lenth_i,
    output logic [NUM_REQ-1:0]        up_gnt_o,
    output logic [NUM_REQ-1:0]        up_r_valid_o,
    output logic [DATA_W-1:0]         up_r_data_o,
    output logic [NUM_REQ-1:0]        up_done_o,
    output logic                      dn_req_o,
    input  logic                      dn_gnt_i,
    output logic [ADDR_W-1:0]         dn_addr_o,
    output logic                      dn_lenth_o,
    input  logic                      dn_r_valid_i,
    input  logic [DATA_W-1:0]         dn_r_data_i,
    output logic                      busy_o,
    output logic                      stray_beat_o
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(2 * BEATS);

    refill_arb_state_e state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              owner_len_q, owner_len_d;
    logic              stray_q, stray_d;
    logic              init_q;

    logic [NUM_REQ-1:0] arb_oh;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;
    logic               quiet;
    logic               last;
    logic [ADDR_W-1:0]  addr_a [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
        assign addr_a[g] = up_addr_i[g*ADDR_W +: ADDR_W];
    end

    rr_arb_core #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .req_i    (up_req_i),
        .ptr_i    (rr_ptr_q),
        .sel_oh_o (arb_oh),
        .sel_idx_o(arb_idx),
        .valid_o  (arb_valid)
    );

    // Outputs stay silent during reset and for the first cycle after it.
    assign quiet       = rst_i | init_q;
    assign last        = last_beat(32'(beat_cnt_q), owner_len_q, BEATS);
    assign up_r_data_o = dn_r_data_i;

    always_ff @(posedge clk_i) begin : p_state
        if (rst_i) state_q <= ARB_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin : p_regs
        if (rst_i) begin
            init_q      <= 1'b1;
            owner_q     <= '0;
            owner_len_q <= 1'b0;
            beat_cnt_q  <= '0;
            rr_ptr_q    <= '0;
            stray_q     <= 1'b0;
        end else begin
            init_q      <= 1'b0;
            owner_q     <= owner_d;
            owner_len_q <= owner_len_d;
            beat_cnt_q  <= beat_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            stray_q     <= stray_d;
        end
    end

    always_comb begin : p_next
        state_d     = state_q;
        owner_d     = owner_q;
        owner_len_d = owner_len_q;
        beat_cnt_d  = beat_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        stray_d     = stray_q | (dn_r_valid_i && (state_q != ARB_XFER));
        unique case (state_q)
            ARB_IDLE: begin
                if (!quiet && arb_valid) begin
                    owner_d     = arb_idx;
                    owner_len_d = up_lenth_i[arb_idx];
                    beat_cnt_d  = '0;
                    state_d     = dn_gnt_i ? ARB_XFER : ARB_HOLD;
                end
            end
            ARB_HOLD: begin
                if (!up_req_i[owner_q]) begin
                    state_d = ARB_IDLE;
                end else if (dn_gnt_i) begin
                    owner_len_d = up_lenth_i[owner_q];
                    beat_cnt_d  = '0;
                    state_d     = ARB_XFER;
                end
            end
            ARB_XFER: begin
                if (dn_r_valid_i) begin
                    if (last) begin
                        beat_cnt_d = '0;
                        rr_ptr_d   = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
                        state_d    = ARB_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin : p_out
        dn_req_o     = 1'b0;
        dn_addr_o    = '0;
        dn_lenth_o   = 1'b0;
        up_gnt_o     = '0;
        up_r_valid_o = '0;
        up_done_o    = '0;
        busy_o       = (state_q != ARB_IDLE) && !rst_i;
        stray_beat_o = stray_q && !rst_i;
        if (!quiet) begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (arb_valid) begin
                        dn_req_o   = 1'b1;
                        dn_addr_o  = addr_a[arb_idx];
                        dn_lenth_o = up_lenth_i[arb_idx];
                        if (dn_gnt_i) up_gnt_o = arb_oh;
                    end
                end
                ARB_HOLD: begin
                    dn_req_o   = up_req_i[owner_q];
                    dn_addr_o  = addr_a[owner_q];
                    dn_lenth_o = up_lenth_i[owner_q];
                    if (up_req_i[owner_q] && dn_gnt_i) up_gnt_o[owner_q] = 1'b1;
                end
                ARB_XFER: begin
                    up_r_valid_o[owner_q] = dn_r_valid_i;
                    up_done_o[owner_q]    = dn_r_valid_i && last;
                end
                default: ;
            endcase
        end
    end

endmodule
